btb_controller: RTL and testbench

Owns and sequences the branch target buffer (BTB) used by the fetch stage for dynamic branch prediction.
- Fetch side: every cycle, performs a combinational lookup on PC_f and returns hit, predicted direction and next-PC.
- Execute side: accepts resolved-branch updates through a valid/ready handshake and maintains 2-bit saturating counters per entry.
- Runs an invalidation sweep FSM after reset and on flush request, clearing one row per cycle.

---
 rtl/btb_controller.sv | 154 +++++++++++++++
 tb/tb_btb_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_controller.sv
// Branch target buffer controller: zero-latency fetch lookup, execute-side
// update with 2-bit saturating direction counters, and an invalidation sweep
// that runs after reset and on flush.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SWEEP | clearing valid of row sweep_idx, one row per cycle
// ST_IDLE  | normal lookup and update operation
module btb_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int BTB_ROWS   = 16,
   parameter int IDX_W      = $clog2(BTB_ROWS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PC_f,
   output logic                  pred_hit,
   output logic                  pred_taken,
   output logic [DATA_WIDTH-1:0] pred_next_pc,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [DATA_WIDTH-1:0] upd_pc,
   input  logic [DATA_WIDTH-1:0] upd_target,
   input  logic                  upd_taken,
   input  logic                  upd_is_jump,
   input  logic                  flush_req,
   output logic                  busy
);

   localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   sweep_idx;

   logic                  row_valid  [BTB_ROWS];
   logic [TAG_W-1:0]      row_tag    [BTB_ROWS];
   logic [DATA_WIDTH-1:0] row_target [BTB_ROWS];
   logic [1:0]            row_pred   [BTB_ROWS];
   logic                  row_jump   [BTB_ROWS];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic             f_taken;

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic             upd_fire;
   logic [1:0]       u_pred_next;

   // Byte-offset bits of both PCs carry no information for a word-aligned BTB.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{PC_f[1:0], upd_pc[1:0]};

   assign f_idx = PC_f[IDX_W+1:2];
   assign f_tag = PC_f[DATA_WIDTH-1:IDX_W+2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[DATA_WIDTH-1:IDX_W+2];

   assign busy      = (state == ST_SWEEP);
   assign upd_ready = (state == ST_IDLE) && !flush_req;
   assign upd_fire  = upd_valid && upd_ready;

   // Fetch-side lookup; reads pre-update contents when an update targets the same row.
   always_comb begin
      f_hit        = (state == ST_IDLE) && row_valid[f_idx] && (row_tag[f_idx] == f_tag);
      f_taken      = f_hit && (row_jump[f_idx] || row_pred[f_idx][1]);
      pred_next_pc = f_taken ? row_target[f_idx] : PC_f + DATA_WIDTH'(4);
   end

   assign pred_hit   = f_hit;
   assign pred_taken = f_taken;

   // Update-side hit detection and saturating counter step.
   always_comb begin
      u_hit       = row_valid[u_idx] && (row_tag[u_idx] == u_tag);
      u_pred_next = row_pred[u_idx];
      if (upd_taken) begin
         if (row_pred[u_idx] != 2'b11) begin
            u_pred_next = row_pred[u_idx] + 2'd1;
         end
      end else begin
         if (row_pred[u_idx] != 2'b00) begin
            u_pred_next = row_pred[u_idx] - 2'd1;
         end
      end
   end

   // Sweep sequencer; a flush at any point restarts the sweep from row 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_SWEEP;
         sweep_idx <= '0;
      end else begin
         case (state)
            ST_SWEEP: begin
               if (flush_req) begin
                  sweep_idx <= '0;
               end else if (sweep_idx == IDX_W'(BTB_ROWS - 1)) begin
                  state     <= ST_IDLE;
                  sweep_idx <= '0;
               end else begin
                  sweep_idx <= sweep_idx + 1'b1;
               end
            end
            ST_IDLE: begin
               if (flush_req) begin
                  state     <= ST_SWEEP;
                  sweep_idx <= '0;
               end
            end
            default: begin
               state     <= ST_SWEEP;
               sweep_idx <= '0;
            end
         endcase
      end
   end

   // Single write port into the array: sweep clears, otherwise accepted updates write.
   // The array has no reset of its own; during reset the state is already
   // ST_SWEEP, so no update can be written.
   always_ff @(posedge clk) begin
      if (state == ST_SWEEP) begin
         row_valid[sweep_idx] <= 1'b0;
      end else if (upd_fire) begin
         if (u_hit) begin
            if (upd_is_jump) begin
               row_jump[u_idx]   <= 1'b1;
               row_target[u_idx] <= upd_target;
               row_pred[u_idx]   <= 2'b11;
            end else begin
               row_pred[u_idx] <= u_pred_next;
               if (upd_taken) begin
                  row_target[u_idx] <= upd_target;
               end
            end
         end else if (upd_taken) begin
            row_valid[u_idx]  <= 1'b1;
            row_tag[u_idx]    <= u_tag;
            row_target[u_idx] <= upd_target;
            row_jump[u_idx]   <= upd_is_jump;
            row_pred[u_idx]   <= upd_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

endmodule

// File: tb/tb_btb_controller.sv
// Bench for btb_controller: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural BTB model.
module tb_btb_controller;

   localparam int DW   = 32;
   localparam int ROWS = 16;

   logic          clk;
   logic          rst;
   logic [DW-1:0] PC_f;
   logic          pred_hit;
   logic          pred_taken;
   logic [DW-1:0] pred_next_pc;
   logic          upd_valid;
   logic          upd_ready;
   logic [DW-1:0] upd_pc;
   logic [DW-1:0] upd_target;
   logic          upd_taken;
   logic          upd_is_jump;
   logic          flush_req;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   btb_controller #(.DATA_WIDTH(DW), .BTB_ROWS(ROWS)) dut (
      .clk          (clk),
      .rst          (rst),
      .PC_f         (PC_f),
      .pred_hit     (pred_hit),
      .pred_taken   (pred_taken),
      .pred_next_pc (pred_next_pc),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .upd_pc       (upd_pc),
      .upd_target   (upd_target),
      .upd_taken    (upd_taken),
      .upd_is_jump  (upd_is_jump),
      .flush_req    (flush_req),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one entry per index, whole-buffer invalidate on
   // reset/flush, and a count of remaining busy cycles.
   bit          m_valid [ROWS];
   logic [31:0] m_hi    [ROWS];
   logic [31:0] m_tgt   [ROWS];
   int          m_pred  [ROWS];
   bit          m_jump  [ROWS];
   int          m_left = ROWS;

   always @(negedge clk) begin
      bit          idle;
      int          i;
      int          j;
      bit          e_hit;
      bit          e_taken;
      logic [31:0] e_next;
      idle    = rst && (m_left == 0);
      i       = int'((PC_f >> 2) % ROWS);
      e_hit   = idle && m_valid[i] && (m_hi[i] == (PC_f >> 6));
      e_taken = e_hit && (m_jump[i] || m_pred[i] >= 2);
      e_next  = e_taken ? m_tgt[i] : PC_f + 32'd4;
      chk("model_busy",   {31'd0, busy},       {31'd0, !idle});
      chk("model_ready",  {31'd0, upd_ready},  {31'd0, idle && !flush_req});
      chk("model_hit",    {31'd0, pred_hit},   {31'd0, e_hit});
      chk("model_taken",  {31'd0, pred_taken}, {31'd0, e_taken});
      chk("model_nextpc", pred_next_pc,        e_next);

      if (!rst || flush_req) begin
         m_left = ROWS;
         for (int k = 0; k < ROWS; k++) m_valid[k] = 0;
      end else if (m_left > 0) begin
         m_left--;
      end else if (upd_valid) begin
         j = int'((upd_pc >> 2) % ROWS);
         if (m_valid[j] && m_hi[j] == (upd_pc >> 6)) begin
            if (upd_is_jump) begin
               m_jump[j] = 1; m_tgt[j] = upd_target; m_pred[j] = 3;
            end else if (upd_taken) begin
               m_pred[j] = (m_pred[j] < 3) ? m_pred[j] + 1 : 3;
               m_tgt[j]  = upd_target;
            end else begin
               m_pred[j] = (m_pred[j] > 0) ? m_pred[j] - 1 : 0;
            end
         end else if (upd_taken) begin
            m_valid[j] = 1; m_hi[j] = upd_pc >> 6; m_tgt[j] = upd_target;
            m_jump[j]  = upd_is_jump; m_pred[j] = upd_is_jump ? 3 : 2;
         end
      end
   end

   // All input changes happen 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit jmp);
      int waited;
      upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_is_jump = jmp;
      waited = 0;
      forever begin
         @(negedge clk);
         if (upd_ready) break;
         waited++;
         if (waited > 40) begin
            chk("upd_ready_timeout", 32'd0, 32'd1);
            break;
         end
         step();
      end
      step();
      upd_valid = 0;
   endtask

   task automatic look(input string name, input logic [31:0] pc, input bit hit, input bit tk, input logic [31:0] nxt);
      PC_f = pc;
      @(negedge clk);
      chk({name, "_hit"},   {31'd0, pred_hit},   {31'd0, hit});
      chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
      chk({name, "_next"},  pred_next_pc,        nxt);
      step();
   endtask

   task automatic expect_busy(input string name, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         chk({name, "_busy"},  {31'd0, busy},      32'd1);
         chk({name, "_ready"}, {31'd0, upd_ready}, 32'd0);
         chk({name, "_hit"},   {31'd0, pred_hit},  32'd0);
         chk({name, "_next"},  pred_next_pc,       PC_f + 32'd4);
         step();
      end
      @(negedge clk);
      chk({name, "_done"}, {31'd0, busy}, 32'd0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tags [5];
      rst = 0; PC_f = 32'h100; upd_valid = 0; upd_pc = 0; upd_target = 0;
      upd_taken = 0; upd_is_jump = 0; flush_req = 0;
      repeat (3) step();
      rst = 1;
      expect_busy("reset_sweep", ROWS);

      do_upd(32'h40, 32'h80, 1, 0);
      look("alloc", 32'h40, 1, 1, 32'h80);
      do_upd(32'h40, 32'h999, 0, 0);
      do_upd(32'h40, 32'h999, 0, 0);
      look("nt2", 32'h40, 1, 0, 32'h44);
      do_upd(32'h40, 32'h999, 0, 0);
      look("nt_floor", 32'h40, 1, 0, 32'h44);
      do_upd(32'h40, 32'h80, 1, 0);
      look("t1_from00", 32'h40, 1, 0, 32'h44);
      repeat (3) do_upd(32'h40, 32'h80, 1, 0);
      do_upd(32'h40, 32'h88, 0, 0);
      look("sat_then_nt", 32'h40, 1, 1, 32'h80);

      do_upd(32'h440, 32'h500, 1, 0);
      look("alias_old", 32'h40, 0, 0, 32'h44);
      look("alias_new", 32'h440, 1, 1, 32'h500);

      do_upd(32'h200, 32'h3F0, 1, 1);
      look("jump", 32'h200, 1, 1, 32'h3F0);
      do_upd(32'h300, 32'h777, 0, 0);
      look("nt_miss", 32'h300, 0, 0, 32'h304);
      look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);

      PC_f = 32'h200;
      flush_req = 1; upd_valid = 1; upd_pc = 32'h80; upd_target = 32'h123;
      upd_taken = 1; upd_is_jump = 0;
      @(negedge clk);
      chk("flush_ready", {31'd0, upd_ready}, 32'd0);
      step();
      flush_req = 0; upd_valid = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("flush_early_busy", {31'd0, busy}, 32'd1);
         step();
      end
      flush_req = 1;
      @(negedge clk);
      step();
      flush_req = 0;
      expect_busy("reflush", ROWS);
      look("flushed_200", 32'h200, 0, 0, 32'h204);
      look("flushed_80", 32'h80, 0, 0, 32'h84);

      do_upd(32'h40, 32'h80, 1, 0);
      upd_valid = 1; upd_pc = 32'h80; upd_target = 32'h60; upd_taken = 1;
      rst = 0;
      @(negedge clk);
      chk("rst_mid_ready", {31'd0, upd_ready}, 32'd0);
      step(); step();
      upd_valid = 0;
      rst = 1;
      expect_busy("rst_mid_sweep", ROWS);
      look("rst_mid_80", 32'h80, 0, 0, 32'h84);
      look("rst_mid_40", 32'h40, 0, 0, 32'h44);

      tags[0] = 0; tags[1] = 1; tags[2] = 2; tags[3] = 3; tags[4] = 32'h03FF_FFFF;
      for (int n = 0; n < 4000; n++) begin
         PC_f        = {tags[$urandom_range(4)][25:0], 4'($urandom), 2'($urandom)};
         upd_pc      = {tags[$urandom_range(4)][25:0], 4'($urandom), 2'($urandom)};
         upd_target  = $urandom;
         upd_valid   = ($urandom_range(1) == 1);
         upd_taken   = ($urandom_range(2) != 0);
         upd_is_jump = ($urandom_range(3) == 0);
         flush_req   = ($urandom_range(149) == 0);
         rst         = ($urandom_range(599) != 0);
         step();
      end
      rst = 1; flush_req = 0; upd_valid = 0;
      step();

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
